// File: rtl/imm_ext_arbiter.sv
// Two-port round-robin arbiter in front of a shared 16->32-bit immediate
// extender. One registered result stage with valid/ready on every port.
module imm_ext_arbiter #(
    parameter int IMM_W     = 16,
    parameter int DATA_W    = 32,
    parameter int FIRST_PRI = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [IMM_W-1:0]  req0_imm,
    input  logic [1:0]        req0_mode,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [IMM_W-1:0]  req1_imm,
    input  logic [1:0]        req1_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    // last_grant starts opposite to FIRST_PRI so the first contended cycle
    // goes to FIRST_PRI.
    localparam logic LAST_GRANT_RST = (FIRST_PRI == 0) ? 1'b1 : 1'b0;

    function automatic logic [31:0] extend_imm(input logic [15:0] imm,
                                               input logic [1:0]  mode);
        logic [31:0] res;
        case (mode)
            2'b00:   res = {{16{imm[15]}}, imm};
            2'b01:   res = {16'h0000, imm};
            2'b10:   res = {imm, 16'h0000};
            2'b11:   res = {{14{imm[15]}}, imm, 2'b00};
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    state_e             state_q;
    logic [DATA_W-1:0]  data_q;
    logic               src_q;
    logic               last_grant_q;

    logic               gnt_valid_s;
    logic               gnt_port_s;
    logic               can_accept_s;
    logic               xfer_s;
    logic [IMM_W-1:0]   sel_imm_s;
    logic [1:0]         sel_mode_s;
    logic [DATA_W-1:0]  ext_data_s;

    // Round-robin grant: contention goes to the port that did not win last.
    always_comb begin
        gnt_valid_s = 1'b0;
        gnt_port_s  = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt_valid_s = 1'b1;
            gnt_port_s  = ~last_grant_q;
        end else if (req0_valid) begin
            gnt_valid_s = 1'b1;
            gnt_port_s  = 1'b0;
        end else if (req1_valid) begin
            gnt_valid_s = 1'b1;
            gnt_port_s  = 1'b1;
        end else begin
            gnt_valid_s = 1'b0;
            gnt_port_s  = 1'b0;
        end
    end

    // Operand mux and extension for the granted port.
    always_comb begin
        sel_imm_s  = req0_imm;
        sel_mode_s = req0_mode;
        if (gnt_port_s) begin
            sel_imm_s  = req1_imm;
            sel_mode_s = req1_mode;
        end else begin
            sel_imm_s  = req0_imm;
            sel_mode_s = req0_mode;
        end
        ext_data_s = extend_imm(sel_imm_s, sel_mode_s);
    end

    assign can_accept_s = (state_q == ST_EMPTY) | out_ready;
    assign xfer_s       = gnt_valid_s & can_accept_s;
    assign req0_ready   = can_accept_s & gnt_valid_s & ~gnt_port_s;
    assign req1_ready   = can_accept_s & gnt_valid_s &  gnt_port_s;

    // Result-stage FSM; a drain and a new accept in the same cycle reload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_EMPTY;
            data_q       <= '0;
            src_q        <= 1'b0;
            last_grant_q <= LAST_GRANT_RST;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (xfer_s) begin
                        state_q      <= ST_FULL;
                        data_q       <= ext_data_s;
                        src_q        <= gnt_port_s;
                        last_grant_q <= gnt_port_s;
                    end
                end
                ST_FULL: begin
                    if (xfer_s) begin
                        data_q       <= ext_data_s;
                        src_q        <= gnt_port_s;
                        last_grant_q <= gnt_port_s;
                    end else if (out_ready) begin
                        state_q <= ST_EMPTY;
                    end
                end
                default: begin
                    state_q <= ST_EMPTY;
                end
            endcase
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_data  = data_q;
    assign out_src   = src_q;

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Scoreboard bench for imm_ext_arbiter: stimulus pushes expected results,
// a negedge monitor pops and compares whenever a result is consumed.
module tb_imm_ext_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready;
    logic [15:0] req0_imm;
    logic [1:0]  req0_mode;
    logic        req1_valid, req1_ready;
    logic [15:0] req1_imm;
    logic [1:0]  req1_mode;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic        out_src;

    typedef struct packed {
        logic [31:0] data;
        logic        src;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    logic [15:0] c0_imm [3] = '{16'h1234, 16'h5678, 16'h9ABC};
    logic [31:0] c0_exp [3] = '{32'h0000_1234, 32'h0000_5678, 32'h0000_9ABC};
    logic [15:0] c1_imm [3] = '{16'h0001, 16'hFFFF, 16'h0100};
    logic [31:0] c1_exp [3] = '{32'h0000_0004, 32'hFFFF_FFFC, 32'h0000_0400};

    imm_ext_arbiter #(.IMM_W(16), .DATA_W(32), .FIRST_PRI(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_imm   (req0_imm),
        .req0_mode  (req0_mode),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_imm   (req1_imm),
        .req1_mode  (req1_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_src    (out_src)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a result is consumed whenever valid and ready meet.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %h src %0d expected none", out_data, out_src);
            end else begin
                mon_e = sb_q.pop_front();
                chk("mon_data", out_data, mon_e.data);
                chk("mon_src", {31'b0, out_src}, {31'b0, mon_e.src});
            end
        end
    end

    // Single-port request: wait (bounded) for ready, push expectation, check latency.
    task automatic send(input logic port, input logic [15:0] imm, input logic [1:0] mode,
                        input logic [31:0] exp);
        int  n;
        logic rdy;
        if (port) begin
            req1_valid = 1'b1; req1_imm = imm; req1_mode = mode;
        end else begin
            req0_valid = 1'b1; req0_imm = imm; req0_mode = mode;
        end
        n = 0;
        @(negedge clk);
        rdy = port ? req1_ready : req0_ready;
        while (!rdy && n < 20) begin
            @(negedge clk);
            n++;
            rdy = port ? req1_ready : req0_ready;
        end
        checks++;
        if (!rdy) begin
            errors++;
            $display("FAIL send_timeout: got ready=0 for port %0d expected ready=1", port);
        end else begin
            sb_q.push_back('{data: exp, src: port});
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (rdy) begin
            chk("lat_valid", {31'b0, out_valid}, 32'd1);
            chk("lat_data", out_data, exp);
            chk("lat_src", {31'b0, out_src}, {31'b0, port});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int i0, i1;
        logic p;
        rst_n = 1'b0; out_ready = 1'b1;
        req0_valid = 1'b1; req0_imm = c0_imm[0]; req0_mode = 2'b01;
        req1_valid = 1'b1; req1_imm = c1_imm[0]; req1_mode = 2'b11;

        // Reset with clock running
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_src", {31'b0, out_src}, 32'd0);
        chk("rst_rdy0", {31'b0, req0_ready}, 32'd1);
        chk("rst_rdy1", {31'b0, req1_ready}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Contention: alternate 0,1,0,1,... with no bubbles
        i0 = 0; i1 = 0;
        for (int k = 0; k < 6; k++) begin
            p = k[0];
            @(negedge clk);
            chk("cont_rdy0", {31'b0, req0_ready}, {31'b0, (p == 1'b0)});
            chk("cont_rdy1", {31'b0, req1_ready}, {31'b0, (p == 1'b1)});
            if (k > 0) chk("cont_no_bubble", {31'b0, out_valid}, 32'd1);
            if (!p) begin
                sb_q.push_back('{data: c0_exp[i0], src: 1'b0});
                i0++;
            end else begin
                sb_q.push_back('{data: c1_exp[i1], src: 1'b1});
                i1++;
            end
            @(posedge clk); #1;
            if (!p && i0 < 3) req0_imm = c0_imm[i0];
            if (p && i1 < 3)  req1_imm = c1_imm[i1];
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1;

        // Extension modes on port 0
        send(1'b0, 16'h8001, 2'b00, 32'hFFFF_8001);
        send(1'b0, 16'h8001, 2'b01, 32'h0000_8001);
        send(1'b0, 16'h8001, 2'b10, 32'h8001_0000);
        send(1'b0, 16'h8001, 2'b11, 32'hFFFE_0004);

        // Drain and accept in the same cycle
        send(1'b0, 16'h8001, 2'b01, 32'h0000_8001);
        send(1'b1, 16'h0004, 2'b11, 32'h0000_0010);
        @(posedge clk); #1;

        // Backpressure holds result and blocks both ports
        out_ready = 1'b0;
        send(1'b0, 16'h7FFF, 2'b00, 32'h0000_7FFF);
        req0_valid = 1'b1; req0_imm = 16'h1111; req0_mode = 2'b01;
        req1_valid = 1'b1; req1_imm = 16'h2222; req1_mode = 2'b00;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_data", out_data, 32'h0000_7FFF);
            chk("bp_rdy0", {31'b0, req0_ready}, 32'd0);
            chk("bp_rdy1", {31'b0, req1_ready}, 32'd0);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_drained", {31'b0, out_valid}, 32'd0);

        // Reset mid-operation drops the held result
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(1'b0, 16'h8001, 2'b00, 32'hFFFF_8001);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_data", out_data, 32'd0);
        sb_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        req0_valid = 1'b1; req0_imm = 16'h0001; req0_mode = 2'b00;
        req1_valid = 1'b1; req1_imm = 16'h0002; req1_mode = 2'b00;
        @(negedge clk);
        chk("midrst_first_pri0", {31'b0, req0_ready}, 32'd1);
        chk("midrst_first_pri1", {31'b0, req1_ready}, 32'd0);
        sb_q.push_back('{data: 32'h0000_0001, src: 1'b0});
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("sb_empty", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
